multicycle_control: RTL

//  Multi-cycle successor of the single-cycle RV32 decoder. An FSM sequences

---
 rtl/multicycle_control.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle RV32 control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP)
//               with memory handshakes, timeout/illegal traps and instret.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32,
    parameter bit EN_JUMPS    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             trap_clear,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       wb_sel,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] c_S_FETCH  = 3'd0;
    localparam logic [2:0] c_S_DECODE = 3'd1;
    localparam logic [2:0] c_S_EXEC   = 3'd2;
    localparam logic [2:0] c_S_MEM    = 3'd3;
    localparam logic [2:0] c_S_WB     = 3'd4;
    localparam logic [2:0] c_S_TRAP   = 3'd5;

    localparam logic [3:0] c_CL_NOP   = 4'd0;
    localparam logic [3:0] c_CL_R     = 4'd1;
    localparam logic [3:0] c_CL_I     = 4'd2;
    localparam logic [3:0] c_CL_LW    = 4'd3;
    localparam logic [3:0] c_CL_SW    = 4'd4;
    localparam logic [3:0] c_CL_LUI   = 4'd5;
    localparam logic [3:0] c_CL_AUIPC = 4'd6;
    localparam logic [3:0] c_CL_BR    = 4'd7;
    localparam logic [3:0] c_CL_JAL   = 4'd8;
    localparam logic [3:0] c_CL_JALR  = 4'd9;
    localparam logic [3:0] c_CL_ILL   = 4'd10;

    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_LW    = 7'b0000011;
    localparam logic [6:0] c_OP_SW    = 7'b0100011;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;

    localparam logic [1:0] c_CAUSE_NONE = 2'd0;
    localparam logic [1:0] c_CAUSE_ILL  = 2'd1;
    localparam logic [1:0] c_CAUSE_IMEM = 2'd2;
    localparam logic [1:0] c_CAUSE_DMEM = 2'd3;

    localparam int c_WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic             r_run;
    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [3:0]       r_class;
    logic [3:0]       w_dec_class;
    logic [1:0]       r_trap_cause;
    logic [1:0]       w_cause_nxt;
    logic [CNT_W-1:0] r_instret;
    logic             w_retire;
    logic             w_req_wait;
    logic             w_timeout;

    // r_run keeps every strobe low until the first edge after reset release.
    always_comb begin
        w_dec_class = c_CL_ILL;
        case (opcode)
            c_OP_R:     w_dec_class = c_CL_R;
            c_OP_I:     w_dec_class = c_CL_I;
            c_OP_LW:    w_dec_class = c_CL_LW;
            c_OP_SW:    w_dec_class = c_CL_SW;
            c_OP_LUI:   w_dec_class = c_CL_LUI;
            c_OP_AUIPC: w_dec_class = EN_JUMPS ? c_CL_AUIPC : c_CL_ILL;
            c_OP_BR:    w_dec_class = EN_JUMPS ? c_CL_BR    : c_CL_ILL;
            c_OP_JAL:   w_dec_class = EN_JUMPS ? c_CL_JAL   : c_CL_ILL;
            c_OP_JALR:  w_dec_class = EN_JUMPS ? c_CL_JALR  : c_CL_ILL;
            default:    w_dec_class = c_CL_ILL;
        endcase
    end

    assign w_req_wait = r_run &&
                        (((r_state == c_S_FETCH) && !imem_ready) ||
                         ((r_state == c_S_MEM)   && !dmem_ready));

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);
            logic [c_WAIT_W-1:0] r_wait_cnt;

            assign w_timeout = w_req_wait && (r_wait_cnt == c_WAIT_LAST);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wait_cnt <= '0;
                end else if (w_req_wait && !w_timeout) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end else begin
                    r_wait_cnt <= '0;
                end
            end
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // A ready in the same cycle as the timeout limit completes the transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_trap_cause;
        w_retire    = 1'b0;
        if (r_run) begin
            case (r_state)
                c_S_FETCH: begin
                    if (imem_ready) begin
                        w_state_nxt = c_S_DECODE;
                    end else if (w_timeout) begin
                        w_state_nxt = c_S_TRAP;
                        w_cause_nxt = c_CAUSE_IMEM;
                    end
                end
                c_S_DECODE: begin
                    if (w_dec_class == c_CL_ILL) begin
                        w_state_nxt = c_S_TRAP;
                        w_cause_nxt = c_CAUSE_ILL;
                    end else begin
                        w_state_nxt = c_S_EXEC;
                    end
                end
                c_S_EXEC: begin
                    case (r_class)
                        c_CL_BR: begin
                            w_state_nxt = c_S_FETCH;
                            w_retire    = 1'b1;
                        end
                        c_CL_LW, c_CL_SW: w_state_nxt = c_S_MEM;
                        default:          w_state_nxt = c_S_WB;
                    endcase
                end
                c_S_MEM: begin
                    if (dmem_ready) begin
                        if (r_class == c_CL_SW) begin
                            w_state_nxt = c_S_FETCH;
                            w_retire    = 1'b1;
                        end else begin
                            w_state_nxt = c_S_WB;
                        end
                    end else if (w_timeout) begin
                        w_state_nxt = c_S_TRAP;
                        w_cause_nxt = c_CAUSE_DMEM;
                    end
                end
                c_S_WB: begin
                    w_state_nxt = c_S_FETCH;
                    w_retire    = 1'b1;
                end
                c_S_TRAP: begin
                    if (trap_clear) begin
                        w_state_nxt = c_S_FETCH;
                        w_cause_nxt = c_CAUSE_NONE;
                    end
                end
                default: w_state_nxt = c_S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run        <= 1'b0;
            r_state      <= c_S_FETCH;
            r_class      <= c_CL_NOP;
            r_trap_cause <= c_CAUSE_NONE;
            r_instret    <= '0;
        end else begin
            r_run        <= 1'b1;
            r_state      <= w_state_nxt;
            r_trap_cause <= w_cause_nxt;
            if (r_run && (r_state == c_S_DECODE)) begin
                r_class <= w_dec_class;
            end
            if (w_retire) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

    always_comb begin
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'd0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        wb_sel        = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 1'b0;
        trap          = 1'b0;
        if (r_run) begin
            case (r_state)
                c_S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                c_S_EXEC: begin
                    case (r_class)
                        c_CL_I, c_CL_LW, c_CL_SW: alu_src_b = 1'b1;
                        c_CL_AUIPC: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 1'b1;
                        end
                        c_CL_BR: begin
                            pc_write_cond = 1'b1;
                            pc_src        = 2'd1;
                        end
                        c_CL_JAL: begin
                            pc_write = 1'b1;
                            pc_src   = 2'd1;
                        end
                        c_CL_JALR: begin
                            pc_write  = 1'b1;
                            pc_src    = 2'd2;
                            alu_src_b = 1'b1;
                        end
                        default: ;
                    endcase
                end
                c_S_MEM: begin
                    dmem_req  = 1'b1;
                    mem_read  = (r_class == c_CL_LW);
                    mem_write = (r_class == c_CL_SW);
                end
                c_S_WB: begin
                    reg_write = 1'b1;
                    case (r_class)
                        c_CL_LW:            wb_sel = 2'd1;
                        c_CL_JAL, c_CL_JALR: wb_sel = 2'd2;
                        c_CL_LUI:           wb_sel = 2'd3;
                        default:            wb_sel = 2'd0;
                    endcase
                end
                c_S_TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign trap_cause = r_trap_cause;
    assign instret    = r_instret;

endmodule

`default_nettype wire
